piezo_sound_arbiter: RTL and testbench

//  Shares the single piezo between three sound sources: alarm (level, highest), hourly chime (pulse, N beeps), key click (pulse, lowest).

---
 rtl/piezo_pkg.sv | 62 ++++++
 rtl/piezo_tone_gen.sv | 28 ++
 rtl/piezo_sound_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_piezo_sound_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo sound arbiter.
// The snooze state exists only when PIEZO_SNOOZE_EN is defined.
package piezo_pkg;

    localparam int unsigned MS_W = 13;

    // Tone half-periods in CLK cycles.
    localparam logic [7:0] KEY_NOTE   = 8'd190;
    localparam logic [7:0] CHIME_NOTE = 8'd127;
    localparam logic [7:0] ALARM_NOTE = 8'd95;

    localparam int unsigned GRANT_KEY   = 0;
    localparam int unsigned GRANT_CHIME = 1;
    localparam int unsigned GRANT_ALARM = 2;

    typedef enum logic [2:0] {
        StIdle,
        StKey,
        StChimeOn,
        StChimeGap,
        StAlarmOn,
        StAlarmOff
`ifdef PIEZO_SNOOZE_EN
        ,
        StSnooze
`endif
    } state_e;

    function automatic logic [2:0] grant_of(input state_e st);
        logic [2:0] g;
        g = '0;
        case (st)
            StKey:                  g[GRANT_KEY]   = 1'b1;
            StChimeOn, StChimeGap:  g[GRANT_CHIME] = 1'b1;
            StAlarmOn, StAlarmOff:  g[GRANT_ALARM] = 1'b1;
`ifdef PIEZO_SNOOZE_EN
            StSnooze:               g[GRANT_ALARM] = 1'b1;
`endif
            default:                g = '0;
        endcase
        return g;
    endfunction

    function automatic logic is_alarm(input state_e st);
        logic [2:0] g;
        g = grant_of(st);
        return g[GRANT_ALARM];
    endfunction

    // Zero means the state is silent.
    function automatic logic [7:0] note_of(input state_e st);
        logic [7:0] n;
        case (st)
            StKey:     n = KEY_NOTE;
            StChimeOn: n = CHIME_NOTE;
            StAlarmOn: n = ALARM_NOTE;
            default:   n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Half-period divider producing the piezo square wave.
// Held cleared (counter 0, output 0) whenever TONE_EN is low.
module piezo_tone_gen (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TONE_EN,
    input  logic [7:0] LIMIT,
    output logic       PIEZO
);

    logic [7:0] cnt_q;
    logic       piezo_q;

    always_ff @(posedge CLK) begin
        if (RESET || !TONE_EN) begin
            cnt_q   <= 8'd0;
            piezo_q <= 1'b0;
        end else if (cnt_q == LIMIT - 8'd1) begin
            cnt_q   <= 8'd0;
            piezo_q <= ~piezo_q;
        end else begin
            cnt_q   <= cnt_q + 8'd1;
        end
    end

    assign PIEZO = piezo_q;

endmodule

// File: rtl/piezo_sound_arbiter.sv
// Arbitrates the piezo between alarm, hourly chime and key click, timing each pattern off TICK_1MS.
// Define PIEZO_SNOOZE_EN to build the snooze state; otherwise the SNOOZE port is ignored.
module piezo_sound_arbiter
    import piezo_pkg::*;
#(
    parameter int unsigned KEY_MS       = 30,
    parameter int unsigned CHIME_ON_MS  = 200,
    parameter int unsigned CHIME_GAP_MS = 200,
    parameter int unsigned ALARM_ON_MS  = 500,
    parameter int unsigned ALARM_OFF_MS = 500,
    parameter int unsigned SNOOZE_MS    = 5000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK_1MS,
    input  logic       ALARM_REQ,
    input  logic       CHIME_REQ,
    input  logic [3:0] CHIME_NUM,
    input  logic       KEY_REQ,
    input  logic       SNOOZE,
    output logic [2:0] GRANT,
    output logic       BUSY,
    output logic       PIEZO
);

    state_e          state_q, state_d;
    logic [MS_W-1:0] ms_q, ms_d, dur;
    logic [3:0]      beeps_q, beeps_d;
    logic            pend_q, pend_d;
    logic [3:0]      pend_num_q, pend_num_d;
    logic [2:0]      grant_q, grant_d;
    logic            chime_ok, done, restart, entry, tone_en;
    logic [7:0]      limit;

`ifdef PIEZO_SNOOZE_EN
    localparam logic [MS_W-1:0] SnoozeDur = MS_W'(SNOOZE_MS);
`else
    logic unused_snooze;
    assign unused_snooze = SNOOZE | (SNOOZE_MS == 0);
`endif

    assign chime_ok = CHIME_REQ && (CHIME_NUM != 4'd0);

    always_comb begin
        dur = '0;
        case (state_q)
            StKey:      dur = MS_W'(KEY_MS);
            StChimeOn:  dur = MS_W'(CHIME_ON_MS);
            StChimeGap: dur = MS_W'(CHIME_GAP_MS);
            StAlarmOn:  dur = MS_W'(ALARM_ON_MS);
            StAlarmOff: dur = MS_W'(ALARM_OFF_MS);
`ifdef PIEZO_SNOOZE_EN
            StSnooze:   dur = SnoozeDur;
`endif
            default:    dur = '0;
        endcase
    end

    assign done = TICK_1MS && (state_q != StIdle) && (ms_q == dur - MS_W'(1));

    always_comb begin
        state_d    = state_q;
        beeps_d    = beeps_q;
        pend_d     = pend_q;
        pend_num_d = pend_num_q;
        restart    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ALARM_REQ) begin
                    state_d = StAlarmOn;
                end else if (chime_ok) begin
                    state_d = StChimeOn;
                    beeps_d = CHIME_NUM;
                    pend_d  = 1'b0;
                end else if (pend_q) begin
                    state_d = StChimeOn;
                    beeps_d = pend_num_q;
                    pend_d  = 1'b0;
                end else if (KEY_REQ) begin
                    state_d = StKey;
                end
            end
            StKey: begin
                if (ALARM_REQ) begin
                    state_d = StAlarmOn;
                end else if (chime_ok) begin
                    state_d = StChimeOn;
                    beeps_d = CHIME_NUM;
                end else if (done) begin
                    state_d = StIdle;
                end
            end
            StChimeOn: begin
                if (ALARM_REQ) begin
                    state_d = StAlarmOn;
                    beeps_d = 4'd0;
                end else if (chime_ok) begin
                    beeps_d = CHIME_NUM;
                    restart = 1'b1;
                end else if (done) begin
                    beeps_d = beeps_q - 4'd1;
                    state_d = (beeps_q <= 4'd1) ? StIdle : StChimeGap;
                end
            end
            StChimeGap: begin
                if (ALARM_REQ) begin
                    state_d = StAlarmOn;
                    beeps_d = 4'd0;
                end else if (chime_ok) begin
                    state_d = StChimeOn;
                    beeps_d = CHIME_NUM;
                end else if (done) begin
                    state_d = StChimeOn;
                end
            end
            StAlarmOn: begin
                if (!ALARM_REQ) begin
                    state_d = StIdle;
                end
`ifdef PIEZO_SNOOZE_EN
                else if (SNOOZE) begin
                    state_d = StSnooze;
                end
`endif
                else if (done) begin
                    state_d = StAlarmOff;
                end
            end
            StAlarmOff: begin
                if (!ALARM_REQ) begin
                    state_d = StIdle;
                end
`ifdef PIEZO_SNOOZE_EN
                else if (SNOOZE) begin
                    state_d = StSnooze;
                end
`endif
                else if (done) begin
                    state_d = StAlarmOn;
                end
            end
`ifdef PIEZO_SNOOZE_EN
            StSnooze: begin
                if (!ALARM_REQ) begin
                    state_d = StIdle;
                end else if (done) begin
                    state_d = StAlarmOn;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        // A chime that arrives while the alarm holds (or takes) the piezo waits its turn.
        if (chime_ok && (is_alarm(state_q) || is_alarm(state_d))) begin
            pend_d     = 1'b1;
            pend_num_d = CHIME_NUM;
        end
    end

    assign entry = (state_d != state_q) || restart;
    assign ms_d  = entry ? '0 :
                   (TICK_1MS && (state_q != StIdle)) ? ms_q + MS_W'(1) : ms_q;

    always_comb begin
        grant_d = grant_of(state_d);
        limit   = note_of(state_d);
        tone_en = (limit != 8'd0) && !entry;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            ms_q       <= '0;
            beeps_q    <= 4'd0;
            pend_q     <= 1'b0;
            pend_num_q <= 4'd0;
            grant_q    <= 3'b000;
        end else begin
            state_q    <= state_d;
            ms_q       <= ms_d;
            beeps_q    <= beeps_d;
            pend_q     <= pend_d;
            pend_num_q <= pend_num_d;
            grant_q    <= grant_d;
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = |grant_q;

    piezo_tone_gen u_tone (
        .CLK     (CLK),
        .RESET   (RESET),
        .TONE_EN (tone_en),
        .LIMIT   (limit),
        .PIEZO   (PIEZO)
    );

endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Self-checking bench for piezo_sound_arbiter: random tick spacing, expectations from the
// pattern durations, priority rules and half-periods.
module tb_piezo_sound_arbiter;

    localparam int KEY_HP = 190, CHIME_HP = 127, ALARM_HP = 95;
    localparam int KEY_T = 30, CHIME_T = 200, GAP_T = 200, ALARM_T = 500, SNOOZE_T = 5000;

    logic       CLK = 1'b0;
    logic       RESET, TICK_1MS, ALARM_REQ, CHIME_REQ, KEY_REQ, SNOOZE;
    logic [3:0] CHIME_NUM;
    logic [2:0] GRANT;
    logic       BUSY, PIEZO;

    always #5 CLK = ~CLK;

    piezo_sound_arbiter u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .TICK_1MS  (TICK_1MS),
        .ALARM_REQ (ALARM_REQ),
        .CHIME_REQ (CHIME_REQ),
        .CHIME_NUM (CHIME_NUM),
        .KEY_REQ   (KEY_REQ),
        .SNOOZE    (SNOOZE),
        .GRANT     (GRANT),
        .BUSY      (BUSY),
        .PIEZO     (PIEZO)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Measurements of the most recent play() segment.
    int         cyc, ntog, ft, mn, mx;
    logic [2:0] gf;
    bit         gs;

    task automatic step(input bit tick);
        TICK_1MS = tick;
        @(posedge CLK);
        #1;
        TICK_1MS  = 1'b0;
        KEY_REQ   = 1'b0;
        CHIME_REQ = 1'b0;
        SNOOZE    = 1'b0;
    endtask

    // Drives n_ticks ticks with random spacing; the last cycle carries the final tick.
    // inj[0]/inj[1] pulse KEY_REQ/SNOOZE on the first cycle.
    task automatic play(input int n_ticks, input int gmin, input int gmax, input logic [1:0] inj);
        bit   bits[$];
        logic prev;
        int   last, iv;
        for (int t = 0; t < n_ticks; t++) begin
            int gap = int'($urandom_range(gmax, gmin));
            for (int g = 0; g < gap; g++) bits.push_back(1'b0);
            bits.push_back(1'b1);
        end
        cyc = 0; ntog = 0; ft = -1; mn = 1 << 30; mx = 0;
        gf = GRANT; gs = 1'b1; prev = PIEZO; last = 0;
        for (int i = 0; i < bits.size(); i++) begin
            if (i == 0) begin
                KEY_REQ = inj[0];
                SNOOZE  = inj[1];
            end
            step(bits[i]);
            cyc++;
            if (i < bits.size() - 1) begin
                if (GRANT !== gf) gs = 1'b0;
                if (PIEZO !== prev) begin
                    ntog++;
                    if (ntog == 1) ft = cyc;
                    else begin
                        iv = cyc - last;
                        if (iv < mn) mn = iv;
                        if (iv > mx) mx = iv;
                    end
                    last = cyc;
                    prev = PIEZO;
                end
            end
        end
    endtask

    function automatic logic [2:0] winner(input bit a, input bit c, input logic [3:0] n, input bit k);
        if (a) return 3'b100;
        if (c && n != 4'd0) return 3'b010;
        if (k) return 3'b001;
        return 3'b000;
    endfunction

    task automatic test_reset();
        RESET = 1'b1; ALARM_REQ = 1'b1; KEY_REQ = 1'b1;
        step(1'b1);
        ALARM_REQ = 1'b0;
        step(1'b0);
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 00000", {GRANT, BUSY, PIEZO});
        end
        RESET = 1'b0;
        step(1'b0);
    endtask

    task automatic test_key();
        KEY_REQ = 1'b1;
        step(1'b0);
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b00110) begin
            n_fail++; $display("FAIL key_entry: got %b want 00110", {GRANT, BUSY, PIEZO});
        end
        play(KEY_T, 8, 20, 2'b00);
        n_checks++;
        if (gf !== 3'b001 || !gs) begin
            n_fail++; $display("FAIL key_grant_hold: got %b stable %0d want 001 stable 1", gf, gs);
        end
        n_checks++;
        if (ntog != (cyc - 1) / KEY_HP || ft != KEY_HP || (ntog > 1 && (mn != KEY_HP || mx != KEY_HP))) begin
            n_fail++; $display("FAIL key_tone: toggles %0d first %0d min %0d max %0d want %0d toggles half %0d",
                               ntog, ft, mn, mx, (cyc - 1) / KEY_HP, KEY_HP);
        end
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b0) begin
            n_fail++; $display("FAIL key_end: got %b want 00000", {GRANT, BUSY, PIEZO});
        end
    endtask

    task automatic test_chime(input logic [3:0] num);
        CHIME_REQ = 1'b1; CHIME_NUM = num;
        step(1'b0);
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b01010) begin
            n_fail++; $display("FAIL chime_entry n=%0d: got %b want 01010", num, {GRANT, BUSY, PIEZO});
        end
        for (int b = 0; b < int'(num); b++) begin
            play(CHIME_T, 0, 2, 2'b00);
            n_checks++;
            if (gf !== 3'b010 || !gs || ntog != (cyc - 1) / CHIME_HP || ft != CHIME_HP ||
                (ntog > 1 && (mn != CHIME_HP || mx != CHIME_HP))) begin
                n_fail++; $display("FAIL chime_beep %0d/%0d: grant %b stable %0d toggles %0d first %0d want 010 1 %0d %0d",
                                   b + 1, num, gf, gs, ntog, ft, (cyc - 1) / CHIME_HP, CHIME_HP);
            end
            if (b < int'(num) - 1) begin
                n_checks++;
                if ({GRANT, PIEZO} !== 4'b0100) begin
                    n_fail++; $display("FAIL chime_gap_entry %0d: got %b want 0100", b + 1, {GRANT, PIEZO});
                end
                play(GAP_T, 0, 2, {1'b0, b == 0});
                n_checks++;
                if (gf !== 3'b010 || !gs || ntog != 0 || GRANT !== 3'b010) begin
                    n_fail++; $display("FAIL chime_gap %0d: grant %b stable %0d toggles %0d after %b want 010 1 0 010",
                                       b + 1, gf, gs, ntog, GRANT);
                end
            end
        end
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b0) begin
            n_fail++; $display("FAIL chime_end n=%0d: got %b want 00000", num, {GRANT, BUSY, PIEZO});
        end
    endtask

    task automatic test_chime_zero_and_restart();
        CHIME_REQ = 1'b1; CHIME_NUM = 4'd0;
        step(1'b0);
        play(5, 0, 2, 2'b00);
        n_checks++;
        if (gf !== 3'b000 || !gs || GRANT !== 3'b000) begin
            n_fail++; $display("FAIL chime_num0: grant %b stable %0d want 000 1", gf, gs);
        end
        CHIME_REQ = 1'b1; CHIME_NUM = 4'd4;
        step(1'b0);
        play(50, 0, 2, 2'b00);
        CHIME_REQ = 1'b1; CHIME_NUM = 4'd1;
        step(1'b0);
        n_checks++;
        if ({GRANT, PIEZO} !== 4'b0100) begin
            n_fail++; $display("FAIL chime_restart_entry: got %b want 0100", {GRANT, PIEZO});
        end
        play(CHIME_T, 0, 2, 2'b00);
        n_checks++;
        if (ft != CHIME_HP || ntog != (cyc - 1) / CHIME_HP || {GRANT, PIEZO} !== 4'b0000) begin
            n_fail++; $display("FAIL chime_restart: first %0d toggles %0d end %b want %0d %0d 0000",
                               ft, ntog, {GRANT, PIEZO}, CHIME_HP, (cyc - 1) / CHIME_HP);
        end
    endtask

    task automatic test_alarm_preempt();
        CHIME_REQ = 1'b1; CHIME_NUM = 4'd5;
        step(1'b0);
        play(CHIME_T, 0, 2, 2'b00);
        play(GAP_T, 0, 2, 2'b00);
        play(150, 0, 2, 2'b00);
        n_checks++;
        if (gf !== 3'b010 || ntog != (cyc - 1) / CHIME_HP || ft != CHIME_HP) begin
            n_fail++; $display("FAIL preempt_beep2: grant %b toggles %0d first %0d want 010 %0d %0d",
                               gf, ntog, ft, (cyc - 1) / CHIME_HP, CHIME_HP);
        end
        ALARM_REQ = 1'b1;
        step(1'b0);
        n_checks++;
        if ({GRANT, PIEZO} !== 4'b1000) begin
            n_fail++; $display("FAIL preempt_entry: got %b want 1000", {GRANT, PIEZO});
        end
        play(ALARM_T, 0, 1, 2'b00);
        n_checks++;
        if (gf !== 3'b100 || !gs || ntog != (cyc - 1) / ALARM_HP || ft != ALARM_HP ||
            (ntog > 1 && (mn != ALARM_HP || mx != ALARM_HP))) begin
            n_fail++; $display("FAIL alarm_on: grant %b stable %0d toggles %0d first %0d min %0d max %0d want %0d half %0d",
                               gf, gs, ntog, ft, mn, mx, (cyc - 1) / ALARM_HP, ALARM_HP);
        end
        n_checks++;
        if ({GRANT, PIEZO} !== 4'b1000) begin
            n_fail++; $display("FAIL alarm_off_entry: got %b want 1000", {GRANT, PIEZO});
        end
        play(ALARM_T, 0, 1, 2'b00);
        n_checks++;
        if (gf !== 3'b100 || !gs || ntog != 0 || GRANT !== 3'b100) begin
            n_fail++; $display("FAIL alarm_off: grant %b stable %0d toggles %0d after %b want 100 1 0 100",
                               gf, gs, ntog, GRANT);
        end
        play(30, 0, 1, 2'b00);
        ALARM_REQ = 1'b0;
        step(1'b0);
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b0) begin
            n_fail++; $display("FAIL alarm_release: got %b want 00000", {GRANT, BUSY, PIEZO});
        end
        play(30, 0, 2, 2'b00);
        n_checks++;
        if (!gs || GRANT !== 3'b000) begin
            n_fail++; $display("FAIL chime_not_resumed: stable %0d grant %b want 1 000", gs, GRANT);
        end
    endtask

    task automatic test_pending();
        ALARM_REQ = 1'b1;
        step(1'b0);
        play(20, 0, 1, 2'b00);
        CHIME_REQ = 1'b1; CHIME_NUM = 4'(int'($urandom_range(4, 3)));
        step(1'b0);
        CHIME_REQ = 1'b1; CHIME_NUM = 4'd2;
        step(1'b0);
        KEY_REQ = 1'b1;
        step(1'b0);
        n_checks++;
        if (GRANT !== 3'b100) begin
            n_fail++; $display("FAIL pending_alarm_hold: got %b want 100", GRANT);
        end
        ALARM_REQ = 1'b0;
        step(1'b0);
        n_checks++;
        if ({GRANT, PIEZO} !== 4'b0000) begin
            n_fail++; $display("FAIL pending_idle: got %b want 0000", {GRANT, PIEZO});
        end
        step(1'b0);
        n_checks++;
        if (GRANT !== 3'b010) begin
            n_fail++; $display("FAIL pending_serve: got %b want 010", GRANT);
        end
        for (int b = 0; b < 2; b++) begin
            play(CHIME_T, 0, 2, 2'b00);
            n_checks++;
            if (gf !== 3'b010 || ntog != (cyc - 1) / CHIME_HP || ft != CHIME_HP) begin
                n_fail++; $display("FAIL pending_beep %0d: grant %b toggles %0d first %0d want 010 %0d %0d",
                                   b + 1, gf, ntog, ft, (cyc - 1) / CHIME_HP, CHIME_HP);
            end
            if (b == 0) play(GAP_T, 0, 2, 2'b00);
        end
        n_checks++;
        if (GRANT !== 3'b000) begin
            n_fail++; $display("FAIL pending_two_beeps: got %b want 000", GRANT);
        end
        play(20, 0, 2, 2'b00);
        n_checks++;
        if (!gs || GRANT !== 3'b000) begin
            n_fail++; $display("FAIL pending_key_dropped: stable %0d grant %b want 1 000", gs, GRANT);
        end
    endtask

    task automatic test_simultaneous_and_reset();
        KEY_REQ = 1'b1; CHIME_REQ = 1'b1; CHIME_NUM = 4'd1;
        step(1'b0);
        n_checks++;
        if (GRANT !== 3'b010) begin
            n_fail++; $display("FAIL simul_key_chime: got %b want 010", GRANT);
        end
        play(CHIME_T, 0, 2, 2'b00);
        play(10, 0, 2, 2'b00);
        n_checks++;
        if (gf !== 3'b000 || !gs || GRANT !== 3'b000) begin
            n_fail++; $display("FAIL simul_key_dropped: grant %b stable %0d want 000 1", gf, gs);
        end
        CHIME_REQ = 1'b1; CHIME_NUM = 4'd3;
        step(1'b0);
        play(50, 0, 2, 2'b00);
        RESET = 1'b1;
        step(1'b0);
        RESET = 1'b0;
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mid_chime: got %b want 00000", {GRANT, BUSY, PIEZO});
        end
        ALARM_REQ = 1'b1;
        step(1'b0);
        CHIME_REQ = 1'b1; CHIME_NUM = 4'd2;
        step(1'b0);
        RESET = 1'b1; ALARM_REQ = 1'b0;
        step(1'b0);
        RESET = 1'b0;
        play(5, 0, 2, 2'b00);
        n_checks++;
        if (!gs || GRANT !== 3'b000) begin
            n_fail++; $display("FAIL reset_drops_pending: stable %0d grant %b want 1 000", gs, GRANT);
        end
    endtask

    task automatic test_priority_random();
        for (int i = 0; i < 10; i++) begin
            bit         a, c, k;
            logic [3:0] n;
            logic [2:0] exp;
            a = 1'($urandom); c = 1'($urandom); k = 1'($urandom); n = 4'($urandom_range(3, 0));
            exp = winner(a, c, n, k);
            ALARM_REQ = a; CHIME_REQ = c; CHIME_NUM = n; KEY_REQ = k;
            step(1'b0);
            n_checks++;
            if (GRANT !== exp) begin
                n_fail++; $display("FAIL prio[%0d] a%0d c%0d n%0d k%0d: got %b want %b", i, a, c, n, k, GRANT, exp);
            end
            if (a && c && n != 4'd0) begin
                ALARM_REQ = 1'b0;
                step(1'b0);
                step(1'b0);
                n_checks++;
                if (GRANT !== 3'b010) begin
                    n_fail++; $display("FAIL prio_pending[%0d]: got %b want 010", i, GRANT);
                end
            end
            RESET = 1'b1; ALARM_REQ = 1'b0;
            step(1'b0);
            RESET = 1'b0;
        end
    endtask

    task automatic test_snooze();
        ALARM_REQ = 1'b1;
        step(1'b0);
        n_checks++;
        if (GRANT !== 3'b100) begin
            n_fail++; $display("FAIL snooze_alarm_entry: got %b want 100", GRANT);
        end
`ifdef PIEZO_SNOOZE_EN
        SNOOZE = 1'b1;
        step(1'b0);
        n_checks++;
        if ({GRANT, PIEZO} !== 4'b1000) begin
            n_fail++; $display("FAIL snooze_entry: got %b want 1000", {GRANT, PIEZO});
        end
        play(SNOOZE_T, 0, 1, 2'b00);
        n_checks++;
        if (gf !== 3'b100 || !gs || ntog != 0 || GRANT !== 3'b100) begin
            n_fail++; $display("FAIL snooze_silent: grant %b stable %0d toggles %0d want 100 1 0", gf, gs, ntog);
        end
        play(ALARM_T, 0, 1, 2'b00);
        n_checks++;
        if (gf !== 3'b100 || ntog != (cyc - 1) / ALARM_HP || ft != ALARM_HP || {GRANT, PIEZO} !== 4'b1000) begin
            n_fail++; $display("FAIL snooze_resume: toggles %0d first %0d end %b want %0d %0d 1000",
                               ntog, ft, {GRANT, PIEZO}, (cyc - 1) / ALARM_HP, ALARM_HP);
        end
`else
        play(ALARM_T, 0, 1, 2'b10);
        n_checks++;
        if (gf !== 3'b100 || !gs || ntog != (cyc - 1) / ALARM_HP || ft != ALARM_HP || {GRANT, PIEZO} !== 4'b1000) begin
            n_fail++; $display("FAIL snooze_ignored: toggles %0d first %0d end %b want %0d %0d 1000",
                               ntog, ft, {GRANT, PIEZO}, (cyc - 1) / ALARM_HP, ALARM_HP);
        end
        play(ALARM_T, 0, 1, 2'b00);
        n_checks++;
        if (ntog != 0 || GRANT !== 3'b100) begin
            n_fail++; $display("FAIL snooze_ignored_off: toggles %0d grant %b want 0 100", ntog, GRANT);
        end
`endif
        ALARM_REQ = 1'b0;
        step(1'b0);
        n_checks++;
        if ({GRANT, BUSY, PIEZO} !== 5'b0) begin
            n_fail++; $display("FAIL snooze_release: got %b want 00000", {GRANT, BUSY, PIEZO});
        end
    endtask

    initial begin
        RESET = 1'b1; TICK_1MS = 1'b0; ALARM_REQ = 1'b0; CHIME_REQ = 1'b0;
        KEY_REQ = 1'b0; SNOOZE = 1'b0; CHIME_NUM = 4'd0;
        test_reset();
        test_key();
        test_chime(4'd3);
        test_chime(4'($urandom_range(4, 1)));
        test_chime_zero_and_restart();
        test_alarm_preempt();
        test_pending();
        test_simultaneous_and_reset();
        test_priority_random();
        test_snooze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
